// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator ALU stage: operation select and
// controller state. Imported by the core and the top-level controller.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_acc_if.sv
// Request/result bundle of the accumulator ALU stage.
// Optional macro ALU_ACC_OVF_FLAG_EN adds the signed-overflow flag ovf.
interface alu_acc_if #(
    parameter int W = 4
);
    logic         start;
    logic         clr;
    logic [1:0]   op;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic         busy;
    logic         done;
    logic         zero;
    logic         carry;
`ifdef ALU_ACC_OVF_FLAG_EN
    logic         ovf;
`endif

    modport master (
        output start, clr, op, b,
`ifdef ALU_ACC_OVF_FLAG_EN
        input  ovf,
`endif
        input  acc, busy, done, zero, carry
    );

    modport slave (
        input  start, clr, op, b,
`ifdef ALU_ACC_OVF_FLAG_EN
        output ovf,
`endif
        output acc, busy, done, zero, carry
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: four operators on acc (a) and b with a 4:1 result select.
// Optional macro ALU_ACC_OVF_FLAG_EN adds the signed-overflow output ovf.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_e          op,
    output logic [W-1:0] res,
`ifdef ALU_ACC_OVF_FLAG_EN
    output logic         ovf,
`endif
    output logic         carry
);

    logic [W:0] sum_add;
    logic [W:0] sum_sub;

    // Subtraction is a + ~b + 1 so the top bit reads as "no borrow".
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

    // Result select and flag generation per operation.
    always_comb begin
        res   = sum_add[W-1:0];
        carry = 1'b0;
`ifdef ALU_ACC_OVF_FLAG_EN
        ovf   = 1'b0;
`endif
        case (op)
            OP_ADD: begin
                res   = sum_add[W-1:0];
                carry = sum_add[W];
`ifdef ALU_ACC_OVF_FLAG_EN
                ovf   = (a[W-1] == b[W-1]) && (sum_add[W-1] != a[W-1]);
`endif
            end
            OP_SUB: begin
                res   = sum_sub[W-1:0];
                carry = sum_sub[W];
`ifdef ALU_ACC_OVF_FLAG_EN
                ovf   = (a[W-1] != b[W-1]) && (sum_sub[W-1] != a[W-1]);
`endif
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            default: res = sum_add[W-1:0];
        endcase
    end

endmodule

// File: rtl/alu_acc.sv
// Accumulator ALU stage: start/busy/done controller around alu_core.
// Optional macro ALU_ACC_OVF_FLAG_EN adds a registered signed-overflow flag.
//
//   state  | meaning
//   S_IDLE | waiting; clr clears acc, start captures op/b
//   S_EXEC | core evaluates captured op; acc/flags load on exit
//   S_DONE | done pulse, new result visible
module alu_acc
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic      clk,
    input  logic      reset,
    alu_acc_if.slave  bus
);

    state_e       state_q;
    op_e          op_q;
    logic [W-1:0] b_q;
    logic [W-1:0] acc_q;
    logic         zero_q;
    logic         carry_q;
    logic         busy_q;
    logic         done_q;
    logic [W-1:0] res_d;
    logic         carry_d;
`ifdef ALU_ACC_OVF_FLAG_EN
    logic         ovf_q;
    logic         ovf_d;
`endif

    alu_core #(.W(W)) u_core (
        .a     (acc_q),
        .b     (b_q),
        .op    (op_q),
        .res   (res_d),
`ifdef ALU_ACC_OVF_FLAG_EN
        .ovf   (ovf_d),
`endif
        .carry (carry_d)
    );

    // Controller, operand capture and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            b_q     <= '0;
            acc_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_ACC_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.clr) begin
                        acc_q   <= '0;
                        zero_q  <= 1'b1;
                        carry_q <= 1'b0;
`ifdef ALU_ACC_OVF_FLAG_EN
                        ovf_q   <= 1'b0;
`endif
                    end else if (bus.start) begin
                        op_q    <= op_e'(bus.op);
                        b_q     <= bus.b;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc_q   <= res_d;
                    zero_q  <= (res_d == '0);
                    carry_q <= carry_d;
`ifdef ALU_ACC_OVF_FLAG_EN
                    ovf_q   <= ovf_d;
`endif
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.acc   = acc_q;
    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
`ifdef ALU_ACC_OVF_FLAG_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_acc.sv
// Self-checking bench for alu_acc: directed vector table, hand-written
// multi-cycle sequences, and random operations against a behavioural model.
module tb_alu_acc;
    localparam int W = 4;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] OR  = 2'b11;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    // Behavioural model state
    int   acc_m;
    int   carry_m;
    int   zero_m;
    int   ovf_m;

    alu_acc_if #(.W(W)) bus_if ();

    alu_acc #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [3:0] b;
        logic [3:0] acc;
        logic       carry;
        logic       zero;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    task automatic model_reset();
        acc_m = 0; carry_m = 0; zero_m = 0; ovf_m = 0;
    endtask

    task automatic model_clr();
        acc_m = 0; carry_m = 0; zero_m = 1; ovf_m = 0;
    endtask

    task automatic model_op(input logic [1:0] o, input logic [3:0] bv);
        int a, bi, s, ss;
        a  = acc_m;
        bi = int'(bv);
        case (o)
            ADD: begin
                s = a + bi; carry_m = (s > 15) ? 1 : 0; acc_m = s % 16;
                ss = sx(a) + sx(bi); ovf_m = (ss > 7 || ss < -8) ? 1 : 0;
            end
            SUB: begin
                s = a - bi; carry_m = (a >= bi) ? 1 : 0; acc_m = (s + 16) % 16;
                ss = sx(a) - sx(bi); ovf_m = (ss > 7 || ss < -8) ? 1 : 0;
            end
            AND: begin acc_m = a & bi; carry_m = 0; ovf_m = 0; end
            default: begin acc_m = a | bi; carry_m = 0; ovf_m = 0; end
        endcase
        zero_m = (acc_m == 0) ? 1 : 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".acc"},   32'(bus_if.acc),   32'(acc_m));
        chk({tag, ".carry"}, 32'(bus_if.carry), 32'(carry_m));
        chk({tag, ".zero"},  32'(bus_if.zero),  32'(zero_m));
`ifdef ALU_ACC_OVF_FLAG_EN
        chk({tag, ".ovf"},   32'(bus_if.ovf),   32'(ovf_m));
`endif
    endtask

    // One full start/busy/done transaction; operands are scrambled after capture.
    task automatic run_op(input logic [1:0] o, input logic [3:0] bv, input string tag,
                          output logic [3:0] acc_s, output logic c_s, output logic z_s);
        model_op(o, bv);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = o; bus_if.b = bv;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.op = 2'($urandom); bus_if.b = 4'($urandom);
        chk({tag, ".exec_busy"}, 32'(bus_if.busy), 32'd1);
        chk({tag, ".exec_done"}, 32'(bus_if.done), 32'd0);
        @(negedge clk);
        chk({tag, ".done"}, 32'(bus_if.done), 32'd1);
        chk({tag, ".busy"}, 32'(bus_if.busy), 32'd1);
        chk_outputs(tag);
        acc_s = bus_if.acc; c_s = bus_if.carry; z_s = bus_if.zero;
        @(negedge clk);
        chk({tag, ".done_fall"}, 32'(bus_if.done), 32'd0);
        chk({tag, ".busy_fall"}, 32'(bus_if.busy), 32'd0);
    endtask

    task automatic do_clr(input logic with_start, input string tag);
        model_clr();
        @(negedge clk);
        bus_if.clr = 1'b1; bus_if.start = with_start; bus_if.op = ADD; bus_if.b = 4'h5;
        @(negedge clk);
        bus_if.clr = 1'b0; bus_if.start = 1'b0;
        chk_outputs(tag);
        chk({tag, ".busy"}, 32'(bus_if.busy), 32'd0);
        chk({tag, ".done"}, 32'(bus_if.done), 32'd0);
        @(negedge clk);
        chk({tag, ".busy2"}, 32'(bus_if.busy), 32'd0);
        chk({tag, ".done2"}, 32'(bus_if.done), 32'd0);
    endtask

    initial begin
        logic [3:0] acc_s;
        logic       c_s, z_s;
        logic [1:0] ro;
        logic [3:0] rb;

        vectors = 0; errors = 0;
        clk = 1'b0; reset = 1'b1;
        bus_if.start = 1'b0; bus_if.clr = 1'b0; bus_if.op = ADD; bus_if.b = '0;
        model_reset();

        tbl = '{
            '{ADD, 4'h3, 4'h3, 1'b0, 1'b0},
            '{ADD, 4'hD, 4'h0, 1'b1, 1'b1},
            '{SUB, 4'h1, 4'hF, 1'b0, 1'b0},
            '{AND, 4'hC, 4'hC, 1'b0, 1'b0},
            '{AND, 4'hA, 4'h8, 1'b0, 1'b0},
            '{OR,  4'h3, 4'hB, 1'b0, 1'b0},
            '{SUB, 4'hB, 4'h0, 1'b1, 1'b1},
            '{ADD, 4'hF, 4'hF, 1'b0, 1'b0},
            '{ADD, 4'h1, 4'h0, 1'b1, 1'b1}
        };

        // Reset held two cycles
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_outputs("reset");
        chk("reset.busy", 32'(bus_if.busy), 32'd0);
        chk("reset.done", 32'(bus_if.done), 32'd0);

        // Directed vector table from a cleared accumulator
        do_clr(1'b0, "clr0");
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].op, tbl[i].b, $sformatf("tbl%0d", i), acc_s, c_s, z_s);
            chk($sformatf("tbl%0d.acc_k", i),   32'(acc_s), 32'(tbl[i].acc));
            chk($sformatf("tbl%0d.carry_k", i), 32'(c_s),   32'(tbl[i].carry));
            chk($sformatf("tbl%0d.zero_k", i),  32'(z_s),   32'(tbl[i].zero));
        end

        // start/clr pulsed while busy are ignored
        model_op(ADD, 4'h2);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = ADD; bus_if.b = 4'h2;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.clr = 1'b1; bus_if.op = OR; bus_if.b = 4'hF;
        @(negedge clk);
        chk("busyign.done", 32'(bus_if.done), 32'd1);
        chk_outputs("busyign");
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.clr = 1'b0;
        chk("busyign.busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        chk("busyign.norestart", 32'(bus_if.busy), 32'd0);
        chk_outputs("busyign.hold");

        // clr together with start: clr wins
        do_clr(1'b1, "clrstart");

        // Reset during EXEC discards the operation
        run_op(ADD, 4'h5, "pre_rst", acc_s, c_s, z_s);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = ADD; bus_if.b = 4'h3;
        @(negedge clk);
        bus_if.start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk_outputs("midrst");
        chk("midrst.busy", 32'(bus_if.busy), 32'd0);
        chk("midrst.done", 32'(bus_if.done), 32'd0);
        @(negedge clk);
        chk("midrst.done2", 32'(bus_if.done), 32'd0);
        chk_outputs("midrst.hold");

`ifdef ALU_ACC_OVF_FLAG_EN
        do_clr(1'b0, "ovfclr");
        run_op(ADD, 4'h7, "ovf0", acc_s, c_s, z_s);
        run_op(ADD, 4'h1, "ovf_add", acc_s, c_s, z_s);
        chk("ovf_add.acc_k", 32'(acc_s), 32'h8);
        chk("ovf_add.ovf_k", 32'(bus_if.ovf), 32'd1);
        run_op(SUB, 4'h1, "ovf_sub", acc_s, c_s, z_s);
        chk("ovf_sub.acc_k", 32'(acc_s), 32'h7);
        chk("ovf_sub.ovf_k", 32'(bus_if.ovf), 32'd1);
`endif

        // Random operations against the model, with idle holds
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(5) == 0) begin
                do_clr(1'($urandom_range(1)), $sformatf("rclr%0d", i));
            end else begin
                ro = 2'($urandom);
                rb = 4'($urandom);
                run_op(ro, rb, $sformatf("rnd%0d", i), acc_s, c_s, z_s);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            chk_outputs($sformatf("idle%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
